// File: rtl/com_test_pattern_gen.sv
// Synthetic Avalon-ST video source: solid background with one programmable
// foreground rectangle, configured through a small Avalon-MM register file.
//
// state | meaning
// IDLE  | no output, waiting for run or single
// HDR   | video header beat (data 0, sop)
// PIX   | W*H pixels in raster order, eop on the last
// GAP   | one idle cycle, frame_done pulse, frame counter update
module com_test_pattern_gen #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [3:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_GAP} state_t;

  localparam logic [10:0] X_LAST = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMAGE_H - 1);

  state_t      state_q, state_n;
  logic [10:0] x_q, y_q, x_n, y_n;
  logic        load_shadow;

  logic        ctrl_run, ctrl_single;
  logic [10:0] rect_x0, rect_y0, rect_x1, rect_y1;
  logic [23:0] fg_colour, bg_colour;
  logic [31:0] frame_count;

  logic [10:0] sh_x0, sh_y0, sh_x1, sh_y1;
  logic [23:0] sh_fg, sh_bg;

  logic        valid_n, sop_n, eop_n, done_n;
  logic [23:0] data_n;
  logic        in_rect;
  logic        accept;
  logic        wr_en, rd_en;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign accept       = source_valid & source_ready;
  assign wr_en        = s_chipselect & s_write;
  assign rd_en        = s_chipselect & s_read;
  assign unused_wdata = ^s_writedata[31:24];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n     = state_q;
    x_n         = x_q;
    y_n         = y_q;
    load_shadow = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (ctrl_run || ctrl_single) begin
          state_n     = S_HDR;
          load_shadow = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_n = S_PIX;
          x_n     = '0;
          y_n     = '0;
        end
      end
      S_PIX: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_n = '0;
            if (y_q == Y_LAST) begin
              state_n = S_GAP;
              y_n     = '0;
            end else begin
              y_n = y_q + 11'd1;
            end
          end else begin
            x_n = x_q + 11'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state/position so they can be registered
  // alongside the state; shadows are stable whenever the next state is PIX.
  always_comb begin
    in_rect = (x_n >= sh_x0) && (x_n <= sh_x1) && (y_n >= sh_y0) && (y_n <= sh_y1);
    valid_n = (state_n == S_HDR) || (state_n == S_PIX);
    sop_n   = (state_n == S_HDR);
    eop_n   = (state_n == S_PIX) && (x_n == X_LAST) && (y_n == Y_LAST);
    done_n  = (state_n == S_GAP);
    data_n  = '0;
    if (state_n == S_PIX) data_n = in_rect ? sh_fg : sh_bg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
      frame_done   <= 1'b0;
      sh_x0        <= '0;
      sh_y0        <= '0;
      sh_x1        <= '0;
      sh_y1        <= '0;
      sh_fg        <= 24'hFFFFFF;
      sh_bg        <= '0;
    end else begin
      x_q          <= x_n;
      y_q          <= y_n;
      source_valid <= valid_n;
      source_sop   <= sop_n;
      source_eop   <= eop_n;
      source_data  <= data_n;
      frame_done   <= done_n;
      if (load_shadow) begin
        sh_x0 <= rect_x0;
        sh_y0 <= rect_y0;
        sh_x1 <= rect_x1;
        sh_y1 <= rect_y1;
        sh_fg <= fg_colour;
        sh_bg <= bg_colour;
      end
    end
  end

  // A CTRL write in the same cycle as a frame start wins over the single clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run    <= 1'b0;
      ctrl_single <= 1'b0;
      rect_x0     <= '0;
      rect_y0     <= '0;
      rect_x1     <= '0;
      rect_y1     <= '0;
      fg_colour   <= 24'hFFFFFF;
      bg_colour   <= '0;
      frame_count <= '0;
    end else begin
      if (wr_en && s_address == 4'd0) begin
        ctrl_run    <= s_writedata[0];
        ctrl_single <= s_writedata[1];
      end else if (load_shadow) begin
        ctrl_single <= 1'b0;
      end
      if (wr_en) begin
        case (s_address)
          4'd1:    rect_x0   <= s_writedata[10:0];
          4'd2:    rect_y0   <= s_writedata[10:0];
          4'd3:    rect_x1   <= s_writedata[10:0];
          4'd4:    rect_y1   <= s_writedata[10:0];
          4'd5:    fg_colour <= s_writedata[23:0];
          4'd6:    bg_colour <= s_writedata[23:0];
          default: ;
        endcase
      end
      if (state_q == S_GAP) frame_count <= frame_count + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      4'd0:    rd_mux = {30'd0, ctrl_single, ctrl_run};
      4'd1:    rd_mux = {21'd0, rect_x0};
      4'd2:    rd_mux = {21'd0, rect_y0};
      4'd3:    rd_mux = {21'd0, rect_x1};
      4'd4:    rd_mux = {21'd0, rect_y1};
      4'd5:    rd_mux = {8'd0, fg_colour};
      4'd6:    rd_mux = {8'd0, bg_colour};
      4'd7:    rd_mux = frame_count;
      4'd8:    rd_mux = {31'd0, (state_q != S_IDLE)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   s_readdata <= '0;
    else if (rd_en) s_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_com_test_pattern_gen.sv
// Randomised bench for com_test_pattern_gen at 8x4: beats are compared against
// a frame model built directly from the rectangle/colour rules.
module tb_com_test_pattern_gen;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [3:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop, frame_done;
  logic        source_ready = 1'b1;

  com_test_pattern_gen #(.IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // stimulus configuration and expectations
  int          cx0, cy0, cx1, cy1;
  logic [23:0] cfg_fg, cfg_bg;
  int          exp_fc = 0;
  bit          bp = 1'b0;
  logic [25:0] exp_q[$];

  // monitor state
  logic [25:0] beats[$];
  int          fd_cnt = 0;
  int          cyc = 0;
  int          fd_times[$];
  bit          hold = 1'b0;
  logic [25:0] held;

  always @(posedge clk) begin
    cyc++;
    #1;
    source_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'd0, source_valid}, 32'd1);
        chk("hold_beat", {6'd0, source_sop, source_eop, source_data}, {6'd0, held});
      end
      if (source_valid && source_ready) beats.push_back({source_sop, source_eop, source_data});
      hold = source_valid && !source_ready;
      held = {source_sop, source_eop, source_data};
      if (frame_done) begin
        fd_cnt++;
        fd_times.push_back(cyc);
      end
    end
  end

  task automatic mm_write(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    s_chipselect = 1'b1; s_write = 1'b1; s_address = 4'(a); s_writedata = d;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic mm_read(input int a, output logic [31:0] d);
    @(posedge clk); #1;
    s_chipselect = 1'b1; s_read = 1'b1; s_address = 4'(a);
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic chk_reg(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] d;
    mm_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic cfg(input int x0, input int y0, input int x1, input int y1,
                     input logic [23:0] fg, input logic [23:0] bg);
    cx0 = x0; cy0 = y0; cx1 = x1; cy1 = y1; cfg_fg = fg; cfg_bg = bg;
    mm_write(1, x0); mm_write(2, y0); mm_write(3, x1); mm_write(4, y1);
    mm_write(5, {8'd0, fg}); mm_write(6, {8'd0, bg});
  endtask

  // Reference frame: header beat then every pixel in raster order.
  task automatic add_frame();
    exp_q.push_back({1'b1, 1'b0, 24'h0});
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bit inr = (x >= cx0) && (x <= cx1) && (y >= cy0) && (y <= cy1);
        exp_q.push_back({1'b0, (x == W-1 && y == H-1), inr ? cfg_fg : cfg_bg});
      end
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_nbeats"}, beats.size(), exp_q.size());
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), {6'd0, beats[i]}, {6'd0, exp_q[i]});
    beats.delete();
    exp_q.delete();
  endtask

  task automatic wait_fd(input int target, input int limit);
    int i = 0;
    while (fd_cnt < target && i < limit) begin
      @(posedge clk);
      i++;
    end
    chk("fd_timeout", {31'd0, fd_cnt >= target}, 32'd1);
  endtask

  task automatic run_single(input string tag);
    int target;
    target = fd_cnt + 1;
    mm_write(0, 2);
    wait_fd(target, 400);
    repeat (3) @(posedge clk);
    chk({tag, "_fd_once"}, fd_cnt, target);
    exp_fc++;
    add_frame();
    compare(tag);
  endtask

  task automatic chk_reset_regs(input string tag);
    chk_reg({tag, "_ctrl"}, 0, 0);
    for (int a = 1; a <= 4; a++) chk_reg($sformatf("%s_rect%0d", tag, a), a, 0);
    chk_reg({tag, "_fg"}, 5, 32'h00FFFFFF);
    chk_reg({tag, "_bg"}, 6, 0);
    chk_reg({tag, "_fc"}, 7, 0);
    chk_reg({tag, "_status"}, 8, 0);
    chk_reg({tag, "_unmapped"}, 11, 0);
  endtask

  initial begin
    int target, base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, source_valid}, 0);
    chk("rst_sop_eop", {30'd0, source_sop, source_eop}, 0);
    chk("rst_data", {8'd0, source_data}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_rdata", s_readdata, 0);
    reset_n = 1'b1;
    chk_reset_regs("reset");
    mm_write(7, 32'h1234);
    chk_reg("fc_ro", 7, 0);

    // single frame, with first-valid latency check
    cfg(2, 1, 4, 2, 24'hFFFFFF, 24'h000000);
    target = fd_cnt + 1;
    mm_write(0, 2);
    chk("lat_n1", {31'd0, source_valid}, 0);
    @(posedge clk); #1;
    chk("lat_n2", {30'd0, source_valid, source_sop}, 32'd3);
    wait_fd(target, 400);
    repeat (3) @(posedge clk);
    chk("single_fd_once", fd_cnt, target);
    exp_fc++;
    add_frame();
    compare("single");
    chk_reg("single_fc", 7, exp_fc);
    chk_reg("single_status", 8, 0);
    chk_reg("single_ctrl", 0, 0);

    // same frame under 50% backpressure
    bp = 1'b1;
    run_single("bp");

    // empty rectangle
    cfg(5, 0, 3, 3, 24'($urandom), 24'($urandom));
    run_single("empty");

    // random rectangles (including out-of-range and inverted) and colours
    for (int k = 0; k < 6; k++) begin
      bp = 1'($urandom_range(0, 1));
      cfg($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
          $urandom_range(0, 5), 24'($urandom), 24'($urandom));
      run_single($sformatf("rnd%0d", k));
    end

    // shadowing: X1 write mid-frame only affects the next frame
    bp = 1'b0;
    cfg(2, 1, 4, 2, 24'hFFFFFF, 24'h000000);
    target = fd_cnt + 1;
    mm_write(0, 2);
    repeat (10) @(posedge clk);
    mm_write(3, 7);
    wait_fd(target, 400);
    repeat (3) @(posedge clk);
    exp_fc++;
    add_frame();
    compare("shadow_a");
    cx1 = 7;
    run_single("shadow_b");

    // continuous run for three frames, run cleared during the third
    fd_times.delete();
    beats.delete();
    base = fd_cnt;
    mm_write(0, 1);
    wait_fd(base + 2, 300);
    repeat (10) @(posedge clk);
    mm_write(0, 0);
    wait_fd(base + 3, 300);
    repeat (5) @(posedge clk);
    chk("cont_nfd", fd_cnt, base + 3);
    if (fd_times.size() >= 3) begin
      chk("cont_period1", fd_times[1] - fd_times[0], W*H + 2);
      chk("cont_period2", fd_times[2] - fd_times[1], W*H + 2);
    end
    repeat (3) add_frame();
    compare("cont");
    exp_fc += 3;
    chk_reg("cont_fc", 7, exp_fc);
    chk_reg("cont_status", 8, 0);
    repeat (40) @(posedge clk);
    chk("cont_idle_beats", beats.size(), 0);

    // asynchronous reset in the middle of the pixel phase
    cfg(1, 1, 6, 2, 24'h00FF00, 24'h0000FF);
    mm_write(0, 2);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, source_valid}, 0);
    chk("arst_flags", {29'd0, source_sop, source_eop, frame_done}, 0);
    chk("arst_data", {8'd0, source_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    beats.delete();
    exp_fc = 0;
    chk_reset_regs("post_rst");
    repeat (40) @(posedge clk);
    chk("post_rst_beats", beats.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
